bcd_countdown_timer: RTL and testbench

//   M:SS countdown timer that generates the BCD digits min, sec_tens and sec_ones.
//   It is the source side of the BCD-to-7-segment decoder, and its digit outputs connect directly to that decoder's inputs.
//   An internal prescaler derives a one-second tick from clk.
//   The digits count down from a loaded value to 0:00, then the block flags expiry.

---
 rtl/bcd_countdown_timer.sv | 173 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// M:SS BCD countdown timer with an internal one-second prescaler, feeding a BCD-to-7-segment decoder.
// Define TIMER_BEEP_EN to add the beep output, which stays high for BEEP_TICKS ticks after expiry.
module bcd_countdown_timer #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_min,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
`ifdef TIMER_BEEP_EN
    ,
    output logic       beep
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam int unsigned       PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_min;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_done;

    logic [3:0]    w_dec_min;
    logic [3:0]    w_dec_tens;
    logic [3:0]    w_dec_ones;
    logic [3:0]    w_ld_min;
    logic [3:0]    w_ld_tens;
    logic [3:0]    w_ld_ones;
    logic          w_tick;
    logic          w_zero;
    logic          w_last_sec;
    logic          w_enter_exp;

    assign w_ld_min   = (load_min      > 4'd9) ? 4'd9 : load_min;
    assign w_ld_tens  = (load_sec_tens > 4'd5) ? 4'd5 : load_sec_tens;
    assign w_ld_ones  = (load_sec_ones > 4'd9) ? 4'd9 : load_sec_ones;

    assign w_tick     = (r_presc == PRESC_MAX);
    assign w_zero     = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_last_sec = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

    // Shared by the state machine (done) and the annunciator (beep rise).
    assign w_enter_exp = !load && (
        ((r_state == S_IDLE || r_state == S_PAUSED) && start && w_zero) ||
        ((r_state == S_RUN) && !stop && w_tick && w_last_sec));

    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else begin
            w_dec_ones = 4'd9;
            if (r_tens != 4'd0) begin
                w_dec_tens = r_tens - 4'd1;
            end else begin
                w_dec_tens = 4'd5;
                w_dec_min  = r_min - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_min   <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_enter_exp;
            if (load) begin
                r_min   <= w_ld_min;
                r_tens  <= w_ld_tens;
                r_ones  <= w_ld_ones;
                r_presc <= '0;
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_PAUSED: begin
                        if (start) begin
                            if (w_zero) begin
                                r_state <= S_EXPIRED;
                                r_presc <= '0;
                            end else begin
                                r_state <= S_RUN;
                                if (r_state == S_IDLE) r_presc <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        // stop beats a coincident tick: state, digits and prescaler all freeze.
                        if (stop) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_presc <= w_tick ? '0 : r_presc + 1'b1;
                            if (w_tick) begin
                                r_min  <= w_dec_min;
                                r_tens <= w_dec_tens;
                                r_ones <= w_dec_ones;
                                if (w_last_sec) r_state <= S_EXPIRED;
                            end
                        end
                    end
                    S_EXPIRED: begin
`ifdef TIMER_BEEP_EN
                        r_presc <= w_tick ? '0 : r_presc + 1'b1;
`else
                        r_presc <= '0;
`endif
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef TIMER_BEEP_EN
    localparam int unsigned   BW        = (BEEP_TICKS > 0) ? $clog2(BEEP_TICKS + 1) : 1;
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_TICKS - 1);

    logic          r_beep;
    logic [BW-1:0] r_beep_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (load) begin
            r_beep     <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_enter_exp) begin
            r_beep     <= 1'b1;
            r_beep_cnt <= '0;
        end else if (r_beep && (r_state == S_EXPIRED) && w_tick) begin
            if (r_beep_cnt == BEEP_LAST) r_beep <= 1'b0;
            r_beep_cnt <= r_beep_cnt + 1'b1;
        end
    end

    assign beep = r_beep;
`else
    if (BEEP_TICKS != 0) begin : g_beep_unused
    end
`endif

    assign min      = r_min;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    assign running  = (r_state == S_RUN);
    assign done     = r_done;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with TICK_DIV=4; beep scenario built only with TIMER_BEEP_EN.
module tb_bcd_countdown_timer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] load_min = '0;
    logic [3:0] load_sec_tens = '0;
    logic [3:0] load_sec_ones = '0;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       done;
`ifdef TIMER_BEEP_EN
    logic       beep;
`endif

    typedef struct packed {
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic       ld;
        logic       st;
        logic       sp;
        logic [3:0] lm;
        logic [3:0] lt;
        logic [3:0] lo;
    } stim_t;

    exp_t  eq[$];
    stim_t sq[$];
    logic  bq[$];
    int    checks = 0;
    int    errors = 0;
    string cur;

    bcd_countdown_timer #(
        .TICK_DIV   (TD),
        .BEEP_TICKS (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .load_min      (load_min),
        .load_sec_tens (load_sec_tens),
        .load_sec_ones (load_sec_ones),
        .start         (start),
        .stop          (stop),
        .min           (min),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .running       (running),
        .done          (done)
`ifdef TIMER_BEEP_EN
        ,
        .beep          (beep)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void pstim(input logic ld, input logic st, input logic sp,
                                  input logic [3:0] lm, input logic [3:0] lt, input logic [3:0] lo);
        stim_t s;
        s = '{ld: ld, st: st, sp: sp, lm: lm, lt: lt, lo: lo};
        sq.push_back(s);
    endfunction

    function automatic void pload(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
        pstim(1'b1, 1'b0, 1'b0, m, t, o);
    endfunction

    function automatic void pidle(input int n);
        for (int i = 0; i < n; i++) pstim(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    endfunction

    function automatic void phold(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                                  input logic run, input logic dn, input int n);
        exp_t e;
        e = '{m: m, t: t, o: o, run: run, done: dn};
        for (int i = 0; i < n; i++) eq.push_back(e);
    endfunction

    // Expected value n cycles into a run, from whole seconds remaining and prescaler phase at entry.
    function automatic void prun(input int start_s, input int phase, input int n);
        bit seen;
        seen = 1'b0;
        for (int c = 1; c <= n; c++) begin
            int   s;
            exp_t e;
            s = start_s - (c + phase) / TD;
            if (s < 0) s = 0;
            e.m    = 4'(s / 60);
            e.t    = 4'((s % 60) / 10);
            e.o    = 4'(s % 10);
            e.run  = (s > 0);
            e.done = (s == 0) && !seen;
            if (s == 0) seen = 1'b1;
            eq.push_back(e);
        end
    endfunction

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        cur = "reset";
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({min, sec_tens, sec_ones, running, done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d:%0d%0d run=%b done=%b, expected 0:00 run=0 done=0",
                     min, sec_tens, sec_ones, running, done);
        end
        rst_n = 1'b1;
        pload(4'd0, 4'd0, 4'd7);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 1);
        prun(7, 0, 5);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({min, sec_tens, sec_ones, running, done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: got %0d:%0d%0d run=%b done=%b, expected 0:00 run=0 done=0",
                     min, sec_tens, sec_ones, running, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({min, sec_tens, sec_ones, running, done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_release: got %0d:%0d%0d run=%b done=%b, expected 0:00 run=0 done=0",
                     min, sec_tens, sec_ones, running, done);
        end
    endtask

    task automatic test_countdown();
        stim_t s;
        exp_t  e;
        cur = "countdown";
        pload(4'd0, 4'd0, 4'd3);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1);
        prun(3, 0, 14);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
    endtask

    task automatic test_borrow();
        stim_t s;
        exp_t  e;
        cur = "borrow";
        pload(4'd1, 4'd0, 4'd0);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1);
        phold(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1);
        prun(60, 0, 44);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
    endtask

    task automatic test_clamp();
        stim_t s;
        exp_t  e;
        cur = "clamp";
        pload(4'hC, 4'h7, 4'hA);
        pidle(1);
        pload(4'd9, 4'd5, 4'd9);
        pload(4'hF, 4'h6, 4'h0);
        pload(4'd9, 4'd5, 4'd9);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd9, 4'd5, 4'd9, 1'b0, 1'b0, 3);
        phold(4'd9, 4'd5, 4'd0, 1'b0, 1'b0, 1);
        phold(4'd9, 4'd5, 4'd9, 1'b0, 1'b0, 1);
        phold(4'd9, 4'd5, 4'd9, 1'b1, 1'b0, 1);
        prun(599, 0, 5);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
    endtask

    task automatic test_pause();
        stim_t s;
        exp_t  e;
        cur = "pause";
        pload(4'd0, 4'd0, 4'd5);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(6);
        pstim(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        pidle(20);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 1);
        prun(5, 0, 6);
        phold(4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 21);
        phold(4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 1);
        prun(4, 2, 14);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
    endtask

    task automatic test_edges();
        stim_t s;
        exp_t  e;
        cur = "edges";
        pload(4'd0, 4'd0, 4'd0);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(2);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pstim(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        pidle(1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 5);
        pload(4'd0, 4'd3, 4'd0);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(3);
        pstim(1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd5);
        pidle(5);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(4);
        phold(4'd0, 4'd3, 4'd0, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd3, 4'd0, 1'b1, 1'b0, 1);
        prun(30, 0, 3);
        phold(4'd2, 4'd1, 4'd5, 1'b0, 1'b0, 6);
        phold(4'd2, 4'd1, 4'd5, 1'b1, 1'b0, 1);
        prun(135, 0, 4);
        pload(4'd0, 4'd0, 4'd2);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(3);
        pstim(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
        pidle(2);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        phold(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1);
        prun(2, 0, 3);
        phold(4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 3);
        phold(4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 1);
        prun(2, 3, 6);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done} !== e) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b, expected %0d:%0d%0d run=%b done=%b",
                         cur, min, sec_tens, sec_ones, running, done, e.m, e.t, e.o, e.run, e.done);
            end
        end
    endtask

`ifdef TIMER_BEEP_EN
    task automatic test_beep();
        stim_t s;
        exp_t  e;
        logic  b;
        cur = "beep";
        pload(4'd0, 4'd0, 4'd1);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(16);
        phold(4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 1);
        prun(1, 0, 16);
        bq.push_back(1'b0);
        bq.push_back(1'b0);
        for (int c = 1; c <= 16; c++) bq.push_back(c >= 4 && c <= 15);
        pload(4'd0, 4'd0, 4'd0);
        pstim(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
        pidle(2);
        pload(4'd0, 4'd0, 4'd0);
        pidle(1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1);
        phold(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        bq.push_back(1'b1);
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b0);
        while (eq.size() > 0) begin
            if (sq.size() > 0) s = sq.pop_front();
            else s = '0;
            load = s.ld; start = s.st; stop = s.sp;
            load_min = s.lm; load_sec_tens = s.lt; load_sec_ones = s.lo;
            tick();
            e = eq.pop_front();
            b = bq.pop_front();
            checks++;
            if ({min, sec_tens, sec_ones, running, done, beep} !== {e, b}) begin
                errors++;
                $display("FAIL %s: got %0d:%0d%0d run=%b done=%b beep=%b, expected %0d:%0d%0d run=%b done=%b beep=%b",
                         cur, min, sec_tens, sec_ones, running, done, beep,
                         e.m, e.t, e.o, e.run, e.done, b);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_borrow();
        test_clamp();
        test_pause();
        test_edges();
`ifdef TIMER_BEEP_EN
        test_beep();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
